// File: rtl/redun_sq_loop.sv
// rtl/redun_sq_loop.sv - iterated-squaring controller driving an external squaring multiplier
// Runs x -> x^2 -> ... -> x^(2^T) with start/ready handshake, abort and multiplier timeout.
module redun_sq_loop #(
   parameter int DAT_BITS = 1024,
   parameter int CNT_BITS = 64,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_start,
   input  logic [DAT_BITS-1:0] i_sq_in,
   input  logic [CNT_BITS-1:0] i_iter,
   input  logic                i_abort,
   output logic                o_ready,
   output logic [DAT_BITS-1:0] o_mul_a,
   output logic                o_mul_val,
   input  logic [DAT_BITS-1:0] i_mul_res,
   input  logic                i_mul_val,
   output logic [DAT_BITS-1:0] o_sq_out,
   output logic                o_valid,
   output logic [CNT_BITS-1:0] o_iter_done,
   output logic                o_err
);

   localparam int TMR_BITS = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DAT_BITS-1:0] acc_q, acc_d;
   logic [DAT_BITS-1:0] sq_out_q, sq_out_d;
   logic [CNT_BITS-1:0] rem_q, rem_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [TMR_BITS-1:0] timer_q, timer_d;

   logic accept;
   logic res_take;
   logic last_iter;
   logic timed_out;

   assign accept    = (state_q == S_IDLE) && i_start && !i_abort;
   assign res_take  = (state_q == S_WAIT) && i_mul_val && !i_abort;
   // cnt_q + 1 never exceeds rem_q, so an all-ones iteration count cannot wrap
   assign last_iter = (cnt_q + CNT_BITS'(1)) == rem_q;
   assign timed_out = timer_q == TMR_BITS'(TIMEOUT - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (i_iter == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: state_d = i_abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            // a result on the final allowed cycle takes priority over the timeout
            if (i_abort) begin
               state_d = S_IDLE;
            end else if (i_mul_val) begin
               state_d = last_iter ? S_DONE : S_ISSUE;
            end else if (timed_out) begin
               state_d = S_ERR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR: begin
            if (i_abort) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready     = (state_q == S_IDLE);
      o_mul_val   = (state_q == S_ISSUE);
      o_valid     = (state_q == S_DONE);
      o_err       = (state_q == S_ERR);
      o_mul_a     = acc_q;
      o_sq_out    = sq_out_q;
      o_iter_done = cnt_q;
   end

   always_comb begin
      acc_d    = acc_q;
      sq_out_d = sq_out_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      if (accept) begin
         acc_d = i_sq_in;
         rem_d = i_iter;
         cnt_d = '0;
         // the result register is loaded on entry to DONE so it is valid alongside o_valid
         if (i_iter == '0) begin
            sq_out_d = i_sq_in;
         end
      end
      if (state_q == S_ISSUE) begin
         timer_d = '0;
      end
      if ((state_q == S_WAIT) && !i_abort) begin
         timer_d = timer_q + TMR_BITS'(1);
      end
      if (res_take) begin
         acc_d = i_mul_res;
         cnt_d = cnt_q + CNT_BITS'(1);
         if (last_iter) begin
            sq_out_d = i_mul_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         sq_out_q <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         sq_out_q <= sq_out_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
      end
   end

endmodule
